// File: rtl/alu_control_md.sv
// ALU operation decoder with an iterative RV M-extension multiply/divide engine.
// Operation is purely combinational; the MD engine runs PREP -> CALC (XLEN cycles) -> FIX -> DONE.
module alu_control_md #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      Funct3,
  input  logic [6:0]      Funct7,
  input  logic [6:0]      op,
  input  logic            start,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      Operation,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MD   = 4'b1111;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2:0]          f3_q, f3_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                is_md;
  logic                md_start;
  logic                unused_op_bits;

  logic                is_div, is_rem;
  logic                signed_a, signed_b;
  logic                sign_a, sign_b;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_by_zero, div_ovf;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;
  logic [XLEN-1:0]     fix_val;

  assign is_md          = (ALUOp == 2'b10) & op[5] & (Funct7 == 7'b0000001);
  assign md_start       = start & is_md;
  assign unused_op_bits = ^{op[6], op[4:0]};

  always_comb begin
    Operation = OP_ADD;
    case (ALUOp)
      2'b00: Operation = OP_ADD;
      2'b01: Operation = OP_SUB;
      2'b10: begin
        if (is_md) begin
          Operation = OP_MD;
        end else begin
          case (Funct3)
            3'b000:  Operation = (op[5] & Funct7[5]) ? OP_SUB : OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b011:  Operation = OP_SLTU;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = Funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  Operation = OP_OR;
            default: Operation = OP_AND;
          endcase
        end
      end
      default: Operation = OP_ADD;
    endcase
  end

  // rs1 is unsigned for MULHU/DIVU/REMU; rs2 additionally unsigned for MULHSU.
  assign is_div   = f3_q[2];
  assign is_rem   = f3_q[2] & f3_q[1];
  assign signed_a = ~(f3_q[0] & (f3_q[1] | f3_q[2]));
  assign signed_b = signed_a & (f3_q != 3'b010);
  assign sign_a   = signed_a & a_q[XLEN-1];
  assign sign_b   = signed_b & b_q[XLEN-1];
  assign abs_a    = sign_a ? -a_q : a_q;
  assign abs_b    = sign_b ? -b_q : b_q;

  assign div_by_zero = is_div & (b_q == '0);
  assign div_ovf     = is_div & ~f3_q[0] & (a_q == MIN_NEG) & (b_q == '1);

  // Both engines share acc: multiply keeps {partial_hi, multiplier}, divide keeps {remainder, quotient}.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift[XLEN-1:0] - b_q;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    if (special_q) begin
      fix_val = acc_q[XLEN-1:0];
    end else if (is_div) begin
      fix_val = f3_q[1] ? rem_fix : quo_fix;
    end else if (f3_q[1:0] == 2'b00) begin
      fix_val = prod_fix[XLEN-1:0];
    end else begin
      fix_val = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (md_start) begin
          state_d = S_PREP;
          a_d     = rs1;
          b_d     = rs2;
          f3_d    = Funct3;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        neg_d = is_rem ? sign_a : (sign_a ^ sign_b);
        if (div_by_zero) begin
          special_d = 1'b1;
          acc_d     = {{XLEN{1'b0}}, (f3_q[1] ? a_q : {XLEN{1'b1}})};
          state_d   = S_FIX;
        end else if (div_ovf) begin
          special_d = 1'b1;
          acc_d     = {{XLEN{1'b0}}, (f3_q[1] ? {XLEN{1'b0}} : a_q)};
          state_d   = S_FIX;
        end else begin
          special_d = 1'b0;
          acc_d     = {{XLEN{1'b0}}, abs_a};
          b_d       = abs_b;
          cnt_d     = CNT_LOAD;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div) begin
          acc_d = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                         : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign md_busy   = busy_q;
  assign md_done   = done_q;
  assign md_result = result_q;

endmodule
